// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx_pkg                                                            |
// | Shared PS/2 host-transmit constants: timing, state codes, command bytes.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ps2_host_tx_pkg;

  // Timing at 50 MHz.
  localparam int c_INHIBIT_CYCLES = 5000;
  localparam int c_START_TIMEOUT  = 750000;
  localparam int c_PACKET_TIMEOUT = 100000;
  localparam int c_TIMER_W        = 20;

  localparam logic [7:0] c_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] c_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] c_CMD_RESET    = 8'hFF;

  localparam int         c_STATE_W     = 4;
  localparam logic [3:0] c_ST_IDLE      = 4'd0;
  localparam logic [3:0] c_ST_INHIBIT   = 4'd1;
  localparam logic [3:0] c_ST_START     = 4'd2;
  localparam logic [3:0] c_ST_REQ       = 4'd3;
  localparam logic [3:0] c_ST_SHIFT     = 4'd4;
  localparam logic [3:0] c_ST_ACK       = 4'd5;
  localparam logic [3:0] c_ST_WAIT_IDLE = 4'd6;
  localparam logic [3:0] c_ST_DONE      = 4'd7;
  localparam logic [3:0] c_ST_ERR       = 4'd8;

  // Bits shifted out after the start bit: d0..d7, odd parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx_sync_edge                                                      |
// | Two-flop synchronizers for PS/2 CLK/DAT plus CLK falling-edge detect.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_host_tx_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic clk_fall_o
);

  logic clk_meta_q;
  logic clk_sync_q;
  logic clk_prev_q;
  logic dat_meta_q;
  logic dat_sync_q;

  // Reset to the idle (released, pulled-up) level so no false edge appears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign clk_sync_o = clk_sync_q;
  assign dat_sync_o = dat_sync_q;
  assign clk_fall_o = clk_prev_q & ~clk_sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx                                                                |
// | PS/2 host-to-device command transmitter with open-drain CLK/DAT drives.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = c_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = c_START_TIMEOUT,
  parameter int PACKET_TIMEOUT = c_PACKET_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       clk_drive_low,
  output logic       dat_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [c_TIMER_W-1:0] c_INHIBIT_LAST = c_TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_START_LAST   = c_TIMER_W'(START_TIMEOUT - 1);
  localparam logic [c_TIMER_W-1:0] c_PACKET_LAST  = c_TIMER_W'(PACKET_TIMEOUT - 1);

  logic                 w_clk_sync;
  logic                 w_dat_sync;
  logic                 w_clk_fall;

  logic [c_STATE_W-1:0] state_q, state_d;
  logic [c_TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [9:0]           shift_q, shift_d;

  ps2_host_tx_sync_edge u_sync (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_dat_i  (ps2_dat_in),
    .clk_sync_o (w_clk_sync),
    .dat_sync_o (w_dat_sync),
    .clk_fall_o (w_clk_fall)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= c_ST_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    case (state_q)
      c_ST_IDLE: begin
        timer_d = '0;
        if (cmd_valid) begin
          shift_d  = build_frame(cmd_byte);
          bitcnt_d = '0;
          state_d  = c_ST_INHIBIT;
        end
      end
      c_ST_INHIBIT: begin
        if (timer_q >= c_INHIBIT_LAST) begin
          timer_d = '0;
          state_d = c_ST_START;
        end
      end
      c_ST_START: begin
        timer_d = '0;
        state_d = c_ST_REQ;
      end
      c_ST_REQ: begin
        // d0 already sits in shift_q[0]; the first fall only starts the packet timer.
        if (w_clk_fall) begin
          timer_d  = '0;
          bitcnt_d = 4'd1;
          state_d  = c_ST_SHIFT;
        end else if (timer_q >= c_START_LAST) begin
          state_d = c_ST_ERR;
        end
      end
      c_ST_SHIFT: begin
        if (timer_q >= c_PACKET_LAST) begin
          state_d = c_ST_ERR;
        end else if (w_clk_fall) begin
          shift_d  = {1'b1, shift_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            state_d = c_ST_ACK;
          end
        end
      end
      c_ST_ACK: begin
        if (timer_q >= c_PACKET_LAST) begin
          state_d = c_ST_ERR;
        end else if (w_clk_fall) begin
          state_d = w_dat_sync ? c_ST_ERR : c_ST_WAIT_IDLE;
        end
      end
      c_ST_WAIT_IDLE: begin
        if (timer_q >= c_PACKET_LAST) begin
          state_d = c_ST_ERR;
        end else if (w_clk_sync && w_dat_sync) begin
          state_d = c_ST_DONE;
        end
      end
      c_ST_DONE, c_ST_ERR: begin
        timer_d = '0;
        state_d = c_ST_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so an async reset releases the bus at once.
  always_comb begin
    cmd_ready     = 1'b0;
    clk_drive_low = 1'b0;
    dat_drive_low = 1'b0;
    tx_done       = 1'b0;
    tx_error      = 1'b0;
    busy          = (state_q != c_ST_IDLE);
    case (state_q)
      c_ST_IDLE:    cmd_ready     = 1'b1;
      c_ST_INHIBIT: clk_drive_low = 1'b1;
      c_ST_START: begin
        clk_drive_low = 1'b1;
        dat_drive_low = 1'b1;
      end
      c_ST_REQ:     dat_drive_low = 1'b1;
      c_ST_SHIFT:   dat_drive_low = ~shift_q[0];
      c_ST_DONE:    tx_done       = 1'b1;
      c_ST_ERR:     tx_error      = 1'b1;
      default:      cmd_ready     = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_host_tx                                                             |
// | Directed bench with a PS/2 device model and a frame scoreboard.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 40;
  localparam int STO  = 1500;
  localparam int PTO  = 2500;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, clk_drive_low, dat_drive_low, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        ps2_clk_pin = ~(clk_drive_low | dev_clk_low);
  wire        ps2_dat_pin = ~(dat_drive_low | dev_dat_low);

  int n_asserts = 0;
  int n_fail    = 0;
  int n_done    = 0;
  int n_err     = 0;
  int cyc       = 0;
  int first_fall_cyc = 0;
  logic [9:0] exp_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .PACKET_TIMEOUT (PTO)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (rst),
    .cmd_byte      (cmd_byte),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .ps2_clk_in    (ps2_clk_pin),
    .ps2_dat_in    (ps2_dat_pin),
    .clk_drive_low (clk_drive_low),
    .dat_drive_low (dat_drive_low),
    .busy          (busy),
    .tx_done       (tx_done),
    .tx_error      (tx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) n_done <= n_done + 1;
    if (tx_error) n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] b);
    @(negedge clk);
    chk("ready_idle", 32'(cmd_ready), 1);
    cmd_byte  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
    exp_q.push_back({1'b1, ~^b, b});
    chk("busy_after_accept", 32'(busy), 1);
  endtask

  // Counts CLK-only-low cycles, then checks the start cycle and REQ entry.
  task automatic inhibit_phase(input bit poke);
    int n = 0;
    if (poke) begin
      cmd_byte  = 8'h55;
      cmd_valid = 1'b1;
      chk("ready_while_busy", 32'(cmd_ready), 0);
    end
    while (clk_drive_low && !dat_drive_low && n < 10 * INH) begin
      n++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
    chk("inhibit_len", 32'(n), 32'(INH));
    chk("start_cycle", {30'd0, clk_drive_low, dat_drive_low}, 32'h3);
    @(negedge clk);
    chk("req_entry", {30'd0, clk_drive_low, dat_drive_low}, 32'h1);
  endtask

  task automatic bfm(input int nfalls, input bit ack, output logic [9:0] cap);
    logic [9:0] exp;
    logic [9:0] mask;
    cap = '1;
    chk("start_bit", 32'(ps2_dat_pin), 0);
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      if (i == 1) first_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      if (i <= 10) cap[i-1] = ps2_dat_pin;
      if (i == 5) chk("busy_mid_frame", 32'(busy), 1);
      dev_clk_low = 1'b0;
      if (i == 11) dev_dat_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      if (i == 10 && ack) dev_dat_low = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    exp = exp_q.pop_front();
    if (nfalls >= 10) begin
      chk("frame", 32'(cap), 32'(exp));
    end else begin
      mask = 10'((1 << nfalls) - 1);
      chk("partial_frame", 32'(cap & mask), 32'(exp & mask));
    end
  endtask

  task automatic do_send(input logic [7:0] b, input logic exp_par, input bit poke);
    logic [9:0] cap;
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    accept(b);
    inhibit_phase(poke);
    bfm(11, 1'b1, cap);
    chk("data_bits", 32'(cap[7:0]), 32'(b));
    chk("parity", 32'(cap[8]), 32'(exp_par));
    chk("stop", 32'(cap[9]), 1);
    repeat (5) @(negedge clk);
    chk("done_once", 32'(n_done - d0), 1);
    chk("no_error", 32'(n_err - e0), 0);
    chk("released_ready", {29'd0, clk_drive_low, dat_drive_low, cmd_ready}, 32'h1);
  endtask

  initial begin
    logic [9:0] cap;
    int n, d0, e0;

    repeat (3) @(negedge clk);
    chk("rst_outputs", {26'd0, cmd_ready, busy, clk_drive_low, dat_drive_low, tx_done, tx_error}, 32'h20);
    rst = 1'b0;

    do_send(c_CMD_SET_LEDS, 1'b1, 1'b1);
    do_send(c_CMD_ENABLE, 1'b0, 1'b0);
    do_send(8'h00, 1'b1, 1'b0);

    // Device never clocks.
    d0 = n_done;
    accept(8'hA5);
    inhibit_phase(1'b0);
    n = 0;
    while (!tx_error && n < STO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", 32'(n), 32'(STO));
    chk("err_released", {30'd0, clk_drive_low, dat_drive_low}, 0);
    @(negedge clk);
    chk("ready_after_err", 32'(cmd_ready), 1);
    void'(exp_q.pop_front());

    // Device omits the ack.
    e0 = n_err;
    accept(8'h5A);
    inhibit_phase(1'b0);
    bfm(11, 1'b0, cap);
    repeat (5) @(negedge clk);
    chk("noack_error", 32'(n_err - e0), 1);
    chk("noack_no_done", 32'(n_done - d0), 0);
    chk("noack_released", {30'd0, clk_drive_low, dat_drive_low}, 0);

    // Device stops after five falls.
    e0 = n_err;
    accept(8'h3C);
    inhibit_phase(1'b0);
    bfm(5, 1'b0, cap);
    n = 0;
    while (!tx_error && n < PTO + 200) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_timeout_window",
        32'((cyc - first_fall_cyc >= PTO) && (cyc - first_fall_cyc <= PTO + 4)), 1);
    @(negedge clk);
    chk("pkt_error_once", 32'(n_err - e0), 1);
    do_send(c_CMD_ENABLE, 1'b0, 1'b0);

    // Reset in the middle of the shift phase.
    d0 = n_done;
    e0 = n_err;
    accept(8'h81);
    inhibit_phase(1'b0);
    bfm(3, 1'b0, cap);
    chk("busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_releases", {29'd0, clk_drive_low, dat_drive_low, busy}, 0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_pulses", 32'((n_done - d0) + (n_err - e0)), 0);
    do_send(c_CMD_RESET, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
